// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the RV32 5-stage hazard unit with scoreboard.
//   fwd_sel_e : forwarding mux select encoding (RF / WB / MEM)
//   RES_LOAD  : ResultSrcE encoding that marks a load in Execute
//   REG_W_DEF : default register index width
// ---------------------------------------------------------------------------
package hazard_pkg;

   localparam int REG_W_DEF = 5;

   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_W  = 2'b01,
      FWD_M  = 2'b10
   } fwd_sel_e;

   localparam logic [1:0] RES_LOAD = 2'b01;

endpackage : hazard_pkg

// File: rtl/hazard_fwd_sel.sv
// ---------------------------------------------------------------------------
// hazard_fwd_sel
// Forwarding select for one Execute-stage source operand.
// MEM stage has priority over WB; register x0 is never forwarded.
// Ports:
//   rs_e_i        in  REG_W  source register in Execute
//   rd_m_i        in  REG_W  destination in Memory
//   reg_write_m_i in  1      Memory writes rd_m_i
//   rd_w_i        in  REG_W  destination in Writeback
//   reg_write_w_i in  1      Writeback writes rd_w_i
//   fwd_o         out 2      10 = MEM, 01 = WB, 00 = register file
// ---------------------------------------------------------------------------
module hazard_fwd_sel
   import hazard_pkg::*;
#(
   parameter int REG_W = REG_W_DEF
) (
   input  logic [REG_W-1:0] rs_e_i,
   input  logic [REG_W-1:0] rd_m_i,
   input  logic             reg_write_m_i,
   input  logic [REG_W-1:0] rd_w_i,
   input  logic             reg_write_w_i,
   output logic [1:0]       fwd_o
);

   fwd_sel_e sel;

   always_comb begin
      sel = FWD_RF;
      if (rs_e_i != '0) begin
         if (reg_write_m_i && (rs_e_i == rd_m_i)) begin
            sel = FWD_M;
         end else if (reg_write_w_i && (rs_e_i == rd_w_i)) begin
            sel = FWD_W;
         end
      end
   end

   assign fwd_o = sel;

endmodule : hazard_fwd_sel

// File: rtl/hazard_unit_sb.sv
// ---------------------------------------------------------------------------
// hazard_unit_sb
// Hazard / forwarding unit for the 5-stage RV32 pipeline with a multi-cycle
// load-use stall and a single-outstanding-op scoreboard for the long-latency
// (MUL/DIV) unit.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   Rs1D, Rs2D, RdD, LongD,
//   RegWriteD                     Decode-stage instruction info
//   Rs1E, Rs2E, RdE, ResultSrcE,
//   LongE, RegWriteE, PCSrcE      Execute-stage instruction info
//   RdM, RegWriteM, RdW,
//   RegWriteW                     Memory / Writeback destinations
//   LongDone, LongRd              long unit completion pulse + destination
//   StallF, StallD                hold PC / IF-ID
//   FlushD, FlushE                bubble IF-ID / ID-EX
//   ForwardAE, ForwardBE          operand forwarding selects
//   LongBusy                      long unit has an op outstanding
// All outputs are combinational from the state and the current inputs.
// ---------------------------------------------------------------------------
module hazard_unit_sb
   import hazard_pkg::*;
#(
   parameter int REG_W      = REG_W_DEF,
   parameter int NREG       = 2**REG_W,
   parameter int LOAD_STALL = 1,
   parameter int CNT_W      = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [REG_W-1:0] Rs1D,
   input  logic [REG_W-1:0] Rs2D,
   input  logic [REG_W-1:0] RdD,
   input  logic             LongD,
   input  logic             RegWriteD,
   input  logic [REG_W-1:0] Rs1E,
   input  logic [REG_W-1:0] Rs2E,
   input  logic [REG_W-1:0] RdE,
   input  logic [1:0]       ResultSrcE,
   input  logic             LongE,
   input  logic             RegWriteE,
   input  logic             PCSrcE,
   input  logic [REG_W-1:0] RdM,
   input  logic [REG_W-1:0] RdW,
   input  logic             RegWriteM,
   input  logic             RegWriteW,
   input  logic             LongDone,
   input  logic [REG_W-1:0] LongRd,
   output logic             StallF,
   output logic             StallD,
   output logic             FlushD,
   output logic             FlushE,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             LongBusy
);

   localparam logic [CNT_W-1:0] LD_RELOAD = CNT_W'(LOAD_STALL - 1);

   logic [NREG-1:0]  busy_q, busy_d;
   logic             long_busy_q, long_busy_d;
   logic [CNT_W-1:0] ld_cnt_q, ld_cnt_d;

   logic ld_hit, sb_hit, stall;
   logic sb_set, sb_clr;

   // ---------------- forwarding ----------------
   hazard_fwd_sel #(.REG_W(REG_W)) u_fwd_a (
      .rs_e_i        (Rs1E),
      .rd_m_i        (RdM),
      .reg_write_m_i (RegWriteM),
      .rd_w_i        (RdW),
      .reg_write_w_i (RegWriteW),
      .fwd_o         (ForwardAE)
   );

   hazard_fwd_sel #(.REG_W(REG_W)) u_fwd_b (
      .rs_e_i        (Rs2E),
      .rd_m_i        (RdM),
      .reg_write_m_i (RegWriteM),
      .rd_w_i        (RdW),
      .reg_write_w_i (RegWriteW),
      .fwd_o         (ForwardBE)
   );

   // ---------------- hazard detection ----------------
   assign ld_hit = (ResultSrcE == RES_LOAD) && RegWriteE && (RdE != '0) &&
                   ((Rs1D == RdE) || (Rs2D == RdE));

   // busy[0] is constant 0, so the x0 qualifiers only document intent.
   assign sb_hit = ((Rs1D != '0) && busy_q[Rs1D]) ||
                   ((Rs2D != '0) && busy_q[Rs2D]) ||
                   (RegWriteD && (RdD != '0) && busy_q[RdD]) ||
                   (LongD && long_busy_q);

   assign stall  = ld_hit || (ld_cnt_q != '0) || sb_hit;

   assign StallF = stall && !PCSrcE;
   assign StallD = stall && !PCSrcE;
   assign FlushD = PCSrcE;
   assign FlushE = stall || PCSrcE;
   assign LongBusy = long_busy_q;

   // ---------------- load-use counter ----------------
   // The hit cycle itself is the first stall cycle, so the counter only
   // covers the remaining LOAD_STALL-1 cycles. A taken branch kills it.
   always_comb begin
      ld_cnt_d = ld_cnt_q;
      if (PCSrcE) begin
         ld_cnt_d = '0;
      end else if (ld_hit) begin
         ld_cnt_d = LD_RELOAD;
      end else if (ld_cnt_q != '0) begin
         ld_cnt_d = ld_cnt_q - CNT_W'(1);
      end
   end

   // ---------------- scoreboard ----------------
   // A long op only claims its destination if it actually advances past E
   // this cycle (not squashed by FlushE).
   assign sb_set = LongE && RegWriteE && (RdE != '0) && !FlushE;
   // Completion with nothing outstanding is a stray pulse and is dropped.
   assign sb_clr = LongDone && long_busy_q;

   // Set is applied after clear, so a same-register set+clear stays busy.
   generate
      for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
         if (gi == 0) begin : g_x0
            assign busy_d[gi] = 1'b0;
         end else begin : g_reg
            assign busy_d[gi] = (sb_set && (RdE == REG_W'(gi))) ||
                                (busy_q[gi] && !(sb_clr && (LongRd == REG_W'(gi))));
         end
      end
   endgenerate

   always_comb begin
      long_busy_d = long_busy_q;
      if (sb_set) begin
         long_busy_d = 1'b1;
      end else if (sb_clr) begin
         long_busy_d = 1'b0;
      end
   end

   // ---------------- state ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q      <= '0;
         long_busy_q <= 1'b0;
         ld_cnt_q    <= '0;
      end else begin
         busy_q      <= busy_d;
         long_busy_q <= long_busy_d;
         ld_cnt_q    <= ld_cnt_d;
      end
   end

endmodule : hazard_unit_sb

// File: tb/tb_hazard_unit_sb.sv
// ---------------------------------------------------------------------------
// tb_hazard_unit_sb
// Directed bench for hazard_unit_sb. Two instances share all inputs:
// dut_a with LOAD_STALL=3, dut_b with LOAD_STALL=1.
// Control outputs are checked packed as {StallF,StallD,FlushD,FlushE,LongBusy}.
// ---------------------------------------------------------------------------
module tb_hazard_unit_sb;

   logic       clk;
   logic       rst_n;
   logic [4:0] Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW, LongRd;
   logic       LongD, RegWriteD, LongE, RegWriteE, PCSrcE;
   logic       RegWriteM, RegWriteW, LongDone;
   logic [1:0] ResultSrcE;

   logic       StallF_a, StallD_a, FlushD_a, FlushE_a, LongBusy_a;
   logic [1:0] FAE_a, FBE_a;
   logic       StallF_b, StallD_b, FlushD_b, FlushE_b, LongBusy_b;
   logic [1:0] FAE_b, FBE_b;

   logic [4:0] ctl_a, ctl_b;
   assign ctl_a = {StallF_a, StallD_a, FlushD_a, FlushE_a, LongBusy_a};
   assign ctl_b = {StallF_b, StallD_b, FlushD_b, FlushE_b, LongBusy_b};

   int n_chk  = 0;
   int n_fail = 0;

   hazard_unit_sb #(.REG_W(5), .NREG(32), .LOAD_STALL(3), .CNT_W(2)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .LongD(LongD), .RegWriteD(RegWriteD),
      .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ResultSrcE(ResultSrcE),
      .LongE(LongE), .RegWriteE(RegWriteE), .PCSrcE(PCSrcE),
      .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .LongDone(LongDone), .LongRd(LongRd),
      .StallF(StallF_a), .StallD(StallD_a), .FlushD(FlushD_a), .FlushE(FlushE_a),
      .ForwardAE(FAE_a), .ForwardBE(FBE_a), .LongBusy(LongBusy_a)
   );

   hazard_unit_sb #(.REG_W(5), .NREG(32), .LOAD_STALL(1), .CNT_W(2)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .LongD(LongD), .RegWriteD(RegWriteD),
      .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ResultSrcE(ResultSrcE),
      .LongE(LongE), .RegWriteE(RegWriteE), .PCSrcE(PCSrcE),
      .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .LongDone(LongDone), .LongRd(LongRd),
      .StallF(StallF_b), .StallD(StallD_b), .FlushD(FlushD_b), .FlushE(FlushE_b),
      .ForwardAE(FAE_b), .ForwardBE(FBE_b), .LongBusy(LongBusy_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
      $display("[%0t] %s observed=%0h expected=%0h", $time, tag, obs, exp);
   endtask

   // advance one clock; inputs are changed 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_e();
      LongE = 0; RegWriteE = 0; RdE = 0; ResultSrcE = 0;
   endtask

   task automatic issue_long(input logic [4:0] rd);
      LongE = 1; RegWriteE = 1; RdE = rd;
      tick();
      clear_e();
   endtask

   initial begin
      rst_n = 0;
      Rs1D = 0; Rs2D = 0; RdD = 0; LongD = 0; RegWriteD = 0;
      Rs1E = 0; Rs2E = 0; RdE = 0; ResultSrcE = 0; LongE = 0; RegWriteE = 0;
      PCSrcE = 0; RdM = 0; RdW = 0; RegWriteM = 0; RegWriteW = 0;
      LongDone = 0; LongRd = 0;

      // ---- reset state ----
      #3;
      chk("reset_ctl_a", 8'(ctl_a), 8'h00);
      chk("reset_ctl_b", 8'(ctl_b), 8'h00);
      chk("reset_fwd",   8'({FAE_a, FBE_a}), 8'h0);
      #5 rst_n = 1;
      tick();

      // ---- forwarding ----
      Rs1E = 5; Rs2E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; #1;
      chk("fwd_m_prio", 8'({FAE_a, FBE_a}), 8'b1010);
      RegWriteM = 0; #1;
      chk("fwd_w", 8'({FAE_a, FBE_a}), 8'b0101);
      Rs1E = 0; #1;
      chk("fwd_x0", 8'({FAE_a, FBE_a}), 8'b0001);
      Rs2E = 6; RdM = 6; RegWriteM = 1; #1;
      chk("fwd_b_m", 8'({FAE_b, FBE_b}), 8'b0010);
      RegWriteM = 0; RegWriteW = 0; #1;
      chk("fwd_none", 8'({FAE_a, FBE_a}), 8'b0000);
      Rs2E = 0; RdM = 0; RdW = 0;

      // ---- load-use: 3 stall cycles on a, 1 on b ----
      tick();
      ResultSrcE = 2'b01; RdE = 7; RegWriteE = 1; Rs2D = 7; #1;
      chk("ld_c0_a", 8'(ctl_a), 8'b11010);
      chk("ld_c0_b", 8'(ctl_b), 8'b11010);
      tick(); clear_e(); #1;
      chk("ld_c1_a", 8'(ctl_a), 8'b11010);
      chk("ld_c1_b", 8'(ctl_b), 8'b00000);
      tick(); #1;
      chk("ld_c2_a", 8'(ctl_a), 8'b11010);
      tick(); #1;
      chk("ld_c3_a", 8'(ctl_a), 8'b00000);
      Rs2D = 0;
      ResultSrcE = 2'b01; RegWriteE = 1; RdE = 0; #1;
      chk("ld_x0", 8'(ctl_a), 8'b00000);
      clear_e();
      tick();

      // ---- long RAW ----
      LongE = 1; RegWriteE = 1; RdE = 9; #1;
      chk("lr_set_cyc", 8'(ctl_a), 8'b00000);
      tick(); clear_e(); #1;
      chk("lr_busy", 8'(ctl_a), 8'b00001);
      Rs1D = 9; #1;
      chk("lr_raw", 8'(ctl_a), 8'b11011);
      tick(); #1;
      chk("lr_hold", 8'(ctl_a), 8'b11011);
      LongDone = 1; LongRd = 9; #1;
      chk("lr_done_cyc", 8'(ctl_a), 8'b11011);
      tick(); LongDone = 0; LongRd = 0; #1;
      chk("lr_release", 8'(ctl_a), 8'b00000);
      Rs1D = 0;

      // ---- structural / WAW ----
      issue_long(9);
      LongD = 1; RdD = 12; #1;
      chk("sw_struct", 8'(ctl_a), 8'b11011);
      LongD = 0; RegWriteD = 1; RdD = 9; #1;
      chk("sw_waw", 8'(ctl_a), 8'b11011);
      RdD = 0; #1;
      chk("sw_waw_x0", 8'(ctl_a), 8'b00001);
      LongD = 1; RdD = 9; LongDone = 1; LongRd = 9; #1;
      chk("sw_done_cyc", 8'(ctl_a), 8'b11011);
      tick(); LongDone = 0; LongRd = 0; #1;
      chk("sw_release", 8'(ctl_a), 8'b00000);
      LongD = 0; RegWriteD = 0; RdD = 0;
      LongDone = 1; LongRd = 3;
      tick(); LongDone = 0; LongRd = 0; #1;
      chk("spurious_done", 8'(ctl_a), 8'b00000);

      // ---- same-cycle set and clear ----
      issue_long(9);
      LongE = 1; RegWriteE = 1; RdE = 10; LongDone = 1; LongRd = 9;
      tick(); clear_e(); LongDone = 0; LongRd = 0; #1;
      chk("sc_longbusy", 8'(ctl_a), 8'b00001);
      Rs1D = 9; #1;
      chk("sc_9_cleared", 8'(ctl_a), 8'b00001);
      Rs1D = 10; #1;
      chk("sc_10_set", 8'(ctl_a), 8'b11011);
      Rs1D = 0;
      LongE = 1; RegWriteE = 1; RdE = 10; LongDone = 1; LongRd = 10;
      tick(); clear_e(); LongDone = 0; LongRd = 0;
      Rs1D = 10; #1;
      chk("sc_equal_stays", 8'(ctl_a), 8'b11011);
      LongDone = 1; LongRd = 10;
      tick(); LongDone = 0; LongRd = 0; #1;
      chk("sc_final_clear", 8'(ctl_a), 8'b00000);
      Rs1D = 0;

      // long op squashed by a taken branch does not claim its register
      LongE = 1; RegWriteE = 1; RdE = 11; PCSrcE = 1;
      tick(); clear_e(); PCSrcE = 0; #1;
      chk("flushed_long", 8'(ctl_a), 8'b00000);

      // ---- branch priority over load stall ----
      issue_long(9);
      ResultSrcE = 2'b01; RegWriteE = 1; RdE = 7; Rs2D = 7; #1;
      chk("br_hit_a", 8'(ctl_a), 8'b11011);
      tick(); clear_e(); Rs2D = 0; #1;
      chk("br_cnt2_a", 8'(ctl_a), 8'b11011);
      chk("br_cnt2_b", 8'(ctl_b), 8'b00001);
      PCSrcE = 1; #1;
      chk("br_flush_a", 8'(ctl_a), 8'b00111);
      chk("br_flush_b", 8'(ctl_b), 8'b00111);
      tick(); PCSrcE = 0; #1;
      chk("br_cnt_cleared", 8'(ctl_a), 8'b00001);
      Rs1D = 9; #1;
      chk("br_busy9_kept", 8'(ctl_a), 8'b11011);
      Rs1D = 0;

      // ---- async reset mid-op ----
      ResultSrcE = 2'b01; RegWriteE = 1; RdE = 7; Rs2D = 7;
      tick(); clear_e(); Rs2D = 0;
      tick(); #1;
      chk("rst_pre_a", 8'(ctl_a), 8'b11011);
      chk("rst_pre_b", 8'(ctl_b), 8'b00001);
      #2 rst_n = 0; #1;
      chk("rst_async_a", 8'(ctl_a), 8'b00000);
      chk("rst_async_b", 8'(ctl_b), 8'b00000);
      #1 rst_n = 1;
      tick();
      Rs1D = 9; #1;
      chk("rst_busy9_gone", 8'(ctl_a), 8'b00000);
      Rs1D = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule : tb_hazard_unit_sb
